// File: rtl/quad_gen_pkg.sv
// quad_gen_pkg: shared FSM encoding, Gray phase constants and phase-step
// helpers for the quadrature pulse generator.
package quad_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // {a,b} Gray phases in increment order
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b10;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b01;

    function automatic logic [1:0] next_phase_up(input logic [1:0] ph);
        case (ph)
            PH0:     return PH1;
            PH1:     return PH2;
            PH2:     return PH3;
            default: return PH0;
        endcase
    endfunction

    function automatic logic [1:0] next_phase_down(input logic [1:0] ph);
        case (ph)
            PH0:     return PH3;
            PH3:     return PH2;
            PH2:     return PH1;
            default: return PH0;
        endcase
    endfunction

endpackage

// File: rtl/quad_tick.sv
// quad_tick: loadable down-counter of PERIOD clocks. While enabled it emits a
// one-cycle tick whenever it reaches zero and then reloads to PERIOD-1.
module quad_tick #(
    parameter int PERIOD = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic reload,
    output logic tick
);

    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == '0);

    // Next count: explicit reload wins, otherwise count down and wrap on tick
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quad_gen.sv
// quad_gen: quadrature pulse generator. Accepts "N edges, direction" commands,
// emits Gray-coded a/b one edge every PERIOD clocks, tracks a running position
// and holds off for one PERIOD of settle time after each command.
// Optional: define QUAD_GEN_INDEX_EN to add the 'index' output, a one-cycle
// pulse on every edge that brings position to zero.
module quad_gen #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic             step_dir,
    input  logic [WIDTH-1:0] step_count,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic [WIDTH-1:0] position
`ifdef QUAD_GEN_INDEX_EN
    ,
    output logic             index
`endif
);

    import quad_gen_pkg::*;

    if (PERIOD < 2) begin : g_period_check
        $error("quad_gen: PERIOD must be >= 2");
    end

    state_e           state_q, state_d;
    logic [1:0]       ab_q, ab_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic             dir_q, dir_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             accept;
    logic             tick;
    logic             edge_go;

    assign step_ready = (state_q == ST_IDLE) && !reset;
    assign accept     = step_valid && step_ready;

    quad_tick #(.PERIOD(PERIOD)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (state_q != ST_IDLE),
        .reload (accept),
        .tick   (tick)
    );

    // Command sequencing, edge generation and position tracking.
    // SETTLE holds one extra cycle after its tick so busy spans the full
    // settle period before step_ready returns.
    always_comb begin
        state_d = state_q;
        ab_d    = ab_q;
        pos_d   = pos_q;
        left_d  = left_q;
        dir_d   = dir_q;
        last_d  = last_q;
        edge_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dir_d   = step_dir;
                    left_d  = step_count;
                    last_d  = 1'b0;
                    state_d = (step_count == '0) ? ST_SETTLE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    edge_go = 1'b1;
                    left_d  = left_q - WIDTH'(1);
                    if (left_q == WIDTH'(1)) begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (last_q) begin
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    last_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (edge_go) begin
            ab_d  = dir_q ? next_phase_up(ab_q) : next_phase_down(ab_q);
            pos_d = dir_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any command with no partial edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ab_q    <= PH0;
            pos_q   <= '0;
            left_q  <= '0;
            dir_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            left_q  <= left_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign a        = ab_q[1];
    assign b        = ab_q[0];
    assign busy     = busy_q;
    assign position = pos_q;

`ifdef QUAD_GEN_INDEX_EN
    logic index_q;
    logic index_d;

    // Index marks the edge whose new position is zero
    always_comb begin
        index_d = edge_go && (pos_d == '0);
    end

    // Index register
    always_ff @(posedge clk) begin
        if (reset) begin
            index_q <= 1'b0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;
`endif

endmodule
